hs_duel_edge_ff: RTL and testbench

Dual-edge input sampler for the MIPI D-PHY high-speed receive path. It captures the HS serial data line on both edges of the DDR bit clock. The rising-edge bit is presented on `parallel_B1` and the falling-edge bit on `parallel_B2`, so the downstream deserializer receives two bits per clock cycle. It sits directly after the HS line receiver and in front of the HS deserializer/word aligner.

---
 rtl/hs_duel_edge_ff.sv | 59 +++++
 tb/tb_hs_duel_edge_ff.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/hs_duel_edge_ff.sv
// Dual-edge HS input sampler: rising-edge bit on parallel_B1, falling-edge bit on parallel_B2.
// Latency: clock-to-q only; B1 updates on rising edges, B2 on falling edges.
// Backpressure: none; deff_en=0 holds both outputs, sampled independently per edge.
//
// Ports:
//   RxDDRClkHS  - HS DDR bit clock, both edges sample
//   RxRst       - synchronous active-high reset, applied per edge domain
//   deff_en     - sample enable; outputs hold while low
//   serial_in   - HS serial data, centre-aligned to both edges
//   parallel_B1 - bit from the most recent enabled rising edge (first of pair)
//   parallel_B2 - bit from the most recent enabled falling edge (second of pair)
module hs_duel_edge_ff (
    input  logic RxDDRClkHS,
    input  logic RxRst,
    input  logic deff_en,
    input  logic serial_in,
    output logic parallel_B1,
    output logic parallel_B2
);

    logic rise_q;
    logic rise_d;
    logic fall_q;
    logic fall_d;

    // Both domains share one priority: reset, then enable, then hold.
    always_comb begin
        rise_d = rise_q;
        if (RxRst) begin
            rise_d = 1'b0;
        end else if (deff_en) begin
            rise_d = serial_in;
        end
    end

    always_comb begin
        fall_d = fall_q;
        if (RxRst) begin
            fall_d = 1'b0;
        end else if (deff_en) begin
            fall_d = serial_in;
        end
    end

    always_ff @(posedge RxDDRClkHS) begin
        rise_q <= rise_d;
    end

    // Falling-edge flop: the second bit of each pair is captured half a cycle
    // after the first, so the pair is only complete between the falling edge
    // and the following rising edge.
    always_ff @(negedge RxDDRClkHS) begin
        fall_q <= fall_d;
    end

    assign parallel_B1 = rise_q;
    assign parallel_B2 = fall_q;

endmodule

// File: tb/tb_hs_duel_edge_ff.sv
module tb_hs_duel_edge_ff;

    logic RxDDRClkHS;
    logic RxRst;
    logic deff_en;
    logic serial_in;
    logic parallel_B1;
    logic parallel_B2;

    hs_duel_edge_ff dut (
        .RxDDRClkHS  (RxDDRClkHS),
        .RxRst       (RxRst),
        .deff_en     (deff_en),
        .serial_in   (serial_in),
        .parallel_B1 (parallel_B1),
        .parallel_B2 (parallel_B2)
    );

    // Rising edges at 10+20k, falling edges at 20+20k.
    initial begin
        RxDDRClkHS = 1'b0;
        forever #10 RxDDRClkHS = ~RxDDRClkHS;
    end

    typedef struct {
        bit    rising;
        bit    b1;
        bit    b2;
        bit    k1;   // b1 defined (a reset or capture has happened)
        bit    k2;
        string tag;
    } exp_t;

    exp_t q[$];
    int   total = 0;
    int   bad   = 0;
    bit   stim_done = 0;

    // Reference state: what each output should hold, and whether it is defined yet.
    bit m_b1, m_b2, m_k1, m_k2;
    bit next_rising = 1'b1;

    task automatic check(input string name, input logic act, input bit exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s t=%0t got=%b want=%b", name, $time, act, exp);
        end
    endtask

    // Drive one half-cycle of stimulus at edge+5, predict the effect of the
    // edge that follows, and wait until the next edge+5.
    task automatic half(input bit rst, input bit en, input bit din, input string tag);
        exp_t e;
        RxRst     = rst;
        deff_en   = en;
        serial_in = din;
        if (next_rising) begin
            if (rst)     begin m_b1 = 1'b0; m_k1 = 1'b1; end
            else if (en) begin m_b1 = din;  m_k1 = 1'b1; end
        end else begin
            if (rst)     begin m_b2 = 1'b0; m_k2 = 1'b1; end
            else if (en) begin m_b2 = din;  m_k2 = 1'b1; end
        end
        e.rising = next_rising;
        e.b1 = m_b1; e.b2 = m_b2; e.k1 = m_k1; e.k2 = m_k2;
        e.tag = tag;
        q.push_back(e);
        next_rising = ~next_rising;
        #10;
    endtask

    // Monitor: after every clock edge, pop the prediction for that edge and
    // compare just after the edge and again after the inputs have moved.
    initial begin
        exp_t e;
        #1;
        forever begin
            @(RxDDRClkHS);
            #2;
            if (q.size() == 0) begin
                if (!stim_done) begin
                    total++;
                    bad++;
                    $display("FAIL queue_empty t=%0t got=no_prediction want=prediction", $time);
                end
            end else begin
                e = q.pop_front();
                if (e.rising !== RxDDRClkHS) begin
                    total++;
                    bad++;
                    $display("FAIL edge_align t=%0t got=%b want=%b", $time, RxDDRClkHS, e.rising);
                end
                if (e.k1) check({e.tag, "_B1"}, parallel_B1, e.b1);
                if (e.k2) check({e.tag, "_B2"}, parallel_B2, e.b2);
                #5;
                // Inputs changed at edge+5; registered outputs must not follow.
                if (e.k1) check({e.tag, "_B1_hold"}, parallel_B1, e.b1);
                if (e.k2) check({e.tag, "_B2_hold"}, parallel_B2, e.b2);
            end
        end
    end

    initial begin
        bit pat [8];
        RxRst = 1'b1; deff_en = 1'b0; serial_in = 1'b0;
        m_b1 = 0; m_b2 = 0; m_k1 = 0; m_k2 = 0;
        #5;

        // Reset with serial_in toggling.
        for (int i = 0; i < 8; i++) half(1'b1, 1'b0, i[0], "reset");
        // Reset beats enable.
        for (int i = 0; i < 4; i++) half(1'b1, 1'b1, 1'b1, "rst_vs_en");

        // Dual-edge capture: 1,0,0,1,1,1,0,1 -> B1 1,0,1,0 / B2 0,1,1,1.
        pat = '{1, 0, 0, 1, 1, 1, 0, 1};
        for (int i = 0; i < 8; i++) half(1'b0, 1'b1, pat[i], "capture");

        // Hold on disable: capture 1/0, then inverse pattern with enable low.
        half(1'b0, 1'b1, 1'b1, "hold_cap");
        half(1'b0, 1'b1, 1'b0, "hold_cap");
        for (int i = 0; i < 3; i++) begin
            half(1'b0, 1'b0, 1'b0, "hold");
            half(1'b0, 1'b0, 1'b1, "hold");
        end

        // Half-cycle disable: clear to 0/0, then enable only for the rising edge.
        half(1'b0, 1'b1, 1'b0, "hc_prep");
        half(1'b0, 1'b1, 1'b0, "hc_prep");
        half(1'b0, 1'b1, 1'b1, "hc_dis");
        half(1'b0, 1'b0, 1'b1, "hc_dis");

        // Mid-stream reset: 1/1, one-cycle reset pulse, then resume.
        half(1'b0, 1'b1, 1'b1, "mid_pre");
        half(1'b0, 1'b1, 1'b1, "mid_pre");
        half(1'b1, 1'b1, 1'b1, "mid_rst");
        half(1'b1, 1'b1, 1'b1, "mid_rst");
        half(1'b0, 1'b1, 1'b1, "mid_resume");
        half(1'b0, 1'b1, 1'b0, "mid_resume");

        // Randomized traffic: mostly enabled, occasional reset.
        for (int i = 0; i < 200; i++) begin
            half($urandom_range(0, 15) == 0,
                 $urandom_range(0, 3) != 0,
                 $urandom_range(0, 1) == 1,
                 "random");
        end

        stim_done = 1'b1;
        #30;
        if (q.size() != 0) begin
            total++;
            bad++;
            $display("FAIL queue_drain got=%0d want=0", q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
